// File: rtl/time_sequencer.sv
// BCD time-of-day keeper with set buttons, 12/24-hour mode and a registered,
// rate-programmable multiplexed 4/6-digit display scan.
module time_sequencer #(
  parameter int DIGITS   = 4,
  parameter int H24      = 0,
  parameter int SCAN_DIV = 1
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Tick,
  input  logic              SyncMinIn,
  input  logic              SyncHourIn,
  output logic [3:0]        D,
  output logic [DIGITS-1:0] Digit,
  output logic              DP,
  output logic              PM,
  output logic [1:0]        hour10,
  output logic [3:0]        hour1,
  output logic [2:0]        min10,
  output logic [3:0]        min1,
  output logic [2:0]        sec10,
  output logic [3:0]        sec1
);

  localparam int         DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [1:0] H10_RST = (H24 != 0) ? 2'd0 : 2'd1;
  localparam logic [3:0] H1_RST  = (H24 != 0) ? 4'd0 : 4'd2;

  generate
    if (!(DIGITS == 4 || DIGITS == 6) || SCAN_DIV < 1) begin : gen_param_check
      $error("time_sequencer: DIGITS must be 4 or 6 and SCAN_DIV must be >= 1");
    end
  endgenerate

  logic [1:0]        hour10_reg, hour10_next;
  logic [3:0]        hour1_reg, hour1_next;
  logic [2:0]        min10_reg, min10_next;
  logic [3:0]        min1_reg, min1_next;
  logic [2:0]        sec10_reg, sec10_next;
  logic [3:0]        sec1_reg, sec1_next;
  logic              pm_reg, pm_next;
  logic              min_btn_reg, hour_btn_reg;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [2:0]        idx_reg, idx_next;
  logic [3:0]        d_reg, d_next;
  logic [DIGITS-1:0] digit_reg, digit_next;
  logic              dp_reg, dp_next;

  logic min_edge, hour_edge, tick_eff, sec_wrap, min_wrap, adv_min, adv_hour;

  assign min_edge  = SyncMinIn & ~min_btn_reg;
  assign hour_edge = SyncHourIn & ~hour_btn_reg;
  // Any set edge swallows a coincident tick so the set result is exact.
  assign tick_eff  = Tick & ~(min_edge | hour_edge);
  assign sec_wrap  = (sec10_reg == 3'd5) && (sec1_reg == 4'd9);
  assign min_wrap  = (min10_reg == 3'd5) && (min1_reg == 4'd9);
  assign adv_min   = min_edge | (tick_eff & sec_wrap);
  assign adv_hour  = hour_edge | (tick_eff & sec_wrap & min_wrap);

  always_comb begin
    sec1_next   = sec1_reg;
    sec10_next  = sec10_reg;
    min1_next   = min1_reg;
    min10_next  = min10_reg;
    hour1_next  = hour1_reg;
    hour10_next = hour10_reg;
    pm_next     = pm_reg;

    if (min_edge) begin
      sec1_next  = 4'd0;
      sec10_next = 3'd0;
    end else if (tick_eff) begin
      if (sec1_reg == 4'd9) begin
        sec1_next  = 4'd0;
        sec10_next = (sec10_reg == 3'd5) ? 3'd0 : sec10_reg + 3'd1;
      end else begin
        sec1_next = sec1_reg + 4'd1;
      end
    end

    if (adv_min) begin
      if (min1_reg == 4'd9) begin
        min1_next  = 4'd0;
        min10_next = (min10_reg == 3'd5) ? 3'd0 : min10_reg + 3'd1;
      end else begin
        min1_next = min1_reg + 4'd1;
      end
    end

    if (adv_hour) begin
      if (H24 != 0) begin
        if (hour10_reg == 2'd2 && hour1_reg == 4'd3) begin
          hour10_next = 2'd0;
          hour1_next  = 4'd0;
        end else if (hour1_reg == 4'd9) begin
          hour10_next = hour10_reg + 2'd1;
          hour1_next  = 4'd0;
        end else begin
          hour1_next = hour1_reg + 4'd1;
        end
      end else begin
        // 12-hour clock runs 12,1,...,11; the meridiem flips entering 12.
        if (hour10_reg == 2'd1 && hour1_reg == 4'd2) begin
          hour10_next = 2'd0;
          hour1_next  = 4'd1;
        end else if (hour10_reg == 2'd1 && hour1_reg == 4'd1) begin
          hour1_next = 4'd2;
          pm_next    = ~pm_reg;
        end else if (hour1_reg == 4'd9) begin
          hour10_next = 2'd1;
          hour1_next  = 4'd0;
        end else begin
          hour1_next = hour1_reg + 4'd1;
        end
      end
    end
  end

  always_comb begin
    div_next = div_reg + DIV_W'(1);
    idx_next = idx_reg;
    if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
      div_next = '0;
      idx_next = (idx_reg == 3'(DIGITS - 1)) ? 3'd0 : idx_reg + 3'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : gen_digit_sel
      assign digit_next[gi] = (idx_reg == 3'(DIGITS - 1 - gi));
    end
  endgenerate

  always_comb begin
    case (idx_reg)
      3'd0:    d_next = (H24 == 0 && hour10_reg == 2'd0) ? 4'hF : {2'b00, hour10_reg};
      3'd1:    d_next = hour1_reg;
      3'd2:    d_next = {1'b0, min10_reg};
      3'd3:    d_next = min1_reg;
      3'd4:    d_next = {1'b0, sec10_reg};
      3'd5:    d_next = sec1_reg;
      default: d_next = 4'hF;
    endcase
    dp_next = 1'b0;
    if (idx_reg == 3'd1 || (DIGITS == 6 && idx_reg == 3'd3)) dp_next = ~sec1_reg[0];
    if (H24 == 0 && idx_reg == 3'(DIGITS - 1)) dp_next = pm_reg;
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      hour10_reg   <= H10_RST;
      hour1_reg    <= H1_RST;
      min10_reg    <= 3'd0;
      min1_reg     <= 4'd0;
      sec10_reg    <= 3'd0;
      sec1_reg     <= 4'd0;
      pm_reg       <= 1'b0;
      min_btn_reg  <= 1'b1;
      hour_btn_reg <= 1'b1;
      div_reg      <= '0;
      idx_reg      <= 3'd0;
      d_reg        <= {2'b00, H10_RST};
      digit_reg    <= {1'b1, {(DIGITS-1){1'b0}}};
      dp_reg       <= 1'b0;
    end else begin
      hour10_reg   <= hour10_next;
      hour1_reg    <= hour1_next;
      min10_reg    <= min10_next;
      min1_reg     <= min1_next;
      sec10_reg    <= sec10_next;
      sec1_reg     <= sec1_next;
      pm_reg       <= pm_next;
      min_btn_reg  <= SyncMinIn;
      hour_btn_reg <= SyncHourIn;
      div_reg      <= div_next;
      idx_reg      <= idx_next;
      d_reg        <= d_next;
      digit_reg    <= digit_next;
      dp_reg       <= dp_next;
    end
  end

  assign hour10 = hour10_reg;
  assign hour1  = hour1_reg;
  assign min10  = min10_reg;
  assign min1   = min1_reg;
  assign sec10  = sec10_reg;
  assign sec1   = sec1_reg;
  assign PM     = pm_reg;
  assign D      = d_reg;
  assign Digit  = digit_reg;
  assign DP     = dp_reg;

endmodule

// File: doc/time_sequencer.md
# time_sequencer

Parametrised successor to the 4-digit clock sequencer. It keeps seconds/minutes/hours time in BCD, advanced by a 1 Hz `Tick`, and accepts minute/hour set buttons. It also drives a multiplexed 4- or 6-digit 7-segment display with a colon blink and a PM indicator. The block sits between the tick prescaler/button synchronisers and the segment decoder/pad drivers, and adds three things the previous block lacks: a 12/24-hour mode, an optional seconds display, and a programmable scan rate.

## Interface
Parameters:
- `DIGITS`, 4, number of display digits; legal values are 4 (HH:MM) and 6 (HH:MM:SS).
- `H24`, 0, hour mode: 1 = 24-hour (00–23), 0 = 12-hour (1–12 with PM flag).
- `SCAN_DIV`, 1, number of Clock cycles each digit stays selected; must be ≥1.

Ports:
- `Clock`  in  1  the single clock for the block.
- `nReset`  in  1  reset, synchronous and active-low.
- `Tick`  in  1  one-cycle pulse, 1 Hz; advances time by one second.
- `SyncMinIn`  in  1  already-synchronised minute-set button level.
- `SyncHourIn`  in  1  already-synchronised hour-set button level.
- `D`  out  4  BCD value of the selected digit; 4'hF = blank.
- `Digit`  out  DIGITS  one-hot digit select; MSB is the leftmost digit (hour10).
- `DP`  out  1  decimal point for the selected digit.
- `PM`  out  1  high for 12:00–11:59 pm in 12-hour mode; always 0 when H24=1.
- `hour10`  out  2  hours tens.
- `hour1`  out  4  hours units.
- `min10`  out  3  minutes tens.
- `min1`  out  4  minutes units.
- `sec10`  out  3  seconds tens.
- `sec1`  out  4  seconds units.

## Operation
- **Reset** (`nReset` low at a Clock edge) forces every register to its reset value:
  - Time: H24=1 gives 00:00:00. H24=0 gives 12:00:00 with PM=0.
  - Scan: scan index selects the leftmost digit and the divider is cleared.
  - Display: Digit = one-hot MSB, D = hour10 reset value (0, or 1 when H24=0), DP = 0.
  - Button edge registers are set to 1, so a button held through reset does not cause an increment.
- **Tick:**
  - sec1 wraps 9→0 and carries into sec10.
  - sec10 wraps 5→0 and carries into minutes.
  - Minutes follow the same pattern (59→00) and carry into hours.
- **Hours, 24h:** 23→00.
- **Hours, 12h:**
  - 11→12 toggles PM; 12→1 does not.
  - hour10 is only ever 0 or 1.
- **Button edge:** a rising edge of a Sync*In input is detected against a 1-cycle delayed copy.
- **Minute set edge:**
  - Minutes +1 with wrap 59→00, no carry into hours.
  - Seconds are cleared to 00.
- **Hour set edge:**
  - Hours +1 using the mode-specific wrap, with no carry into minutes.
  - In 12h mode, PM toggles on 11→12 exactly as for a carry.
- **Priority:**
  - If any set edge occurs in a cycle, a coincident Tick is discarded entirely.
  - Both set edges in the same cycle are both applied.
- **Scan:**
  - The divider counts 0..SCAN_DIV-1.
  - On the cycle it equals SCAN_DIV-1, the divider wraps to 0 and the index advances one digit right.
  - The index wraps from the rightmost digit back to the leftmost.
- **Digit order:**
  - DIGITS=4: hour10, hour1, min10, min1.
  - DIGITS=6: the same four, followed by sec10, sec1.
- **Display D:**
  - D is the BCD value of the selected digit, zero-extended to 4 bits.
  - In 12h mode, hour10 = 0 displays as 4'hF (leading-zero blank); Digit is still asserted.
- **Display DP:**
  - Colon: DP = ~sec1[0] when hour1 is selected.
  - When DIGITS=6, the same colon rule also applies when min1 is selected.
  - PM: DP = PM when the rightmost digit is selected in 12h mode.
  - DP = 0 for all other digits.
- **Illegal DIGITS/SCAN_DIV:** rejected at elaboration.

## Timing
- Time outputs are registers and change on the Clock edge that samples the Tick/edge condition.
- Button to count: a button rising at edge N (first sampled high) changes the count at edge N, visible after it. A button held high produces exactly one increment.
- D/Digit/DP are registered from the scan index and the time registers, giving a 1-cycle latency from either changing.
- Each digit is selected for exactly SCAN_DIV cycles. With SCAN_DIV=1, Digit rotates every cycle.
- Reset is synchronous and has priority over Tick, set edges and scan. Asserting it mid-scan or mid-carry returns all outputs to their reset values after that edge.

## Test plan
- **Reset and 24h carry:** H24=1, DIGITS=6; reset, then 86399 Ticks → 23:59:59. One more Tick → 00:00:00 with PM=0.
- **12h wrap and PM:** H24=0; reset gives 12:00:00, PM=0.
  - 3600 Ticks → 01:00:00.
  - Hour-set to 11:59:59, then one Tick → 12:00:00 and PM=1.
  - Check D=4'hF while hour10 is selected at 1:00.
- **Set priority:** at 10:22:37, assert a SyncMinIn edge together with Tick → 10:23:00. The Tick is lost.
- **Set wrap without carry:**
  - At 10:59:xx, a minute edge → 10:00:00.
  - At 23:xx, an hour edge → 00:xx.
  - Holding SyncHourIn high for 10 cycles gives exactly one increment.
- **Scan:** DIGITS=4, SCAN_DIV=3.
  - Digit sequence 1000,1000,1000,0100,…,0001, then back to 1000.
  - DP is high only on the 0100 slot, and only when sec1 is even.
  - D matches the time with a 1-cycle lag.
- **Reset mid-operation:** assert nReset low for 1 cycle during a min1 carry with SCAN_DIV=2.
  - Next cycle: all time outputs are at reset values, Digit = MSB one-hot, DP = 0.
  - A button held across reset produces no increment.
